// File: rtl/sadder_pkg.sv
// Shared types and helpers for the pipelined saturating add/subtract unit.
// Helpers take the operand width as an argument so one package serves any WIDTH up to MAX_WIDTH.
`timescale 1ns/1ps
package sadder_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned IDX_W     = $clog2(MAX_WIDTH + 1);

  typedef logic [MAX_WIDTH:0]   exact_t;
  typedef logic [MAX_WIDTH-1:0] word_t;

  typedef struct packed {
    logic  ovf;
    word_t res;
  } sat_res_t;

  // Most positive value at the given width (0x7F..F), zero-extended.
  function automatic word_t sat_max(input int unsigned width);
    word_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width - 1) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Most negative value at the given width (0x80..0) in the low width bits.
  function automatic word_t sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

  // exact is the sign-extended (width+1)-bit result; overflow when its top two bits differ.
  function automatic sat_res_t sat_sel(input exact_t exact, input logic sat_en,
                                       input int unsigned width);
    sat_res_t r;
    r.ovf = exact[IDX_W'(width)] ^ exact[IDX_W'(width - 1)];
    r.res = exact[MAX_WIDTH-1:0];
    if (r.ovf && sat_en) begin
      r.res = exact[IDX_W'(width)] ? sat_min(width) : sat_max(width);
    end
    return r;
  endfunction

endpackage

// File: rtl/sadder_core.sv
// Combinational exact add/subtract with one extra carry bit so overflow stays observable.
`timescale 1ns/1ps
module sadder_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum_c,
  output logic [WIDTH:0]   diff_c
);

  always_comb begin
    sum_c  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    diff_c = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  end

endmodule

// File: rtl/sadder_pipe.sv
// Two-stage signed add/subtract with per-beat wrap/saturate and valid/ready on both sides.
// in_ready is combinational from out_ready through the stall-in-place chain.
`timescale 1ns/1ps
module sadder_pipe
  import sadder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] diff,
  output logic             ovf_sum,
  output logic             ovf_diff
);

  logic             s1_valid;
  logic             s1_sat;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH:0]   exact_sum_c;
  logic [WIDTH:0]   exact_diff_c;
  logic [WIDTH:0]   sum_sel_c;
  logic [WIDTH:0]   diff_sel_c;

  // Returns {ovf, result} for one exact (WIDTH+1)-bit value.
  function automatic logic [WIDTH:0] pick(input logic [WIDTH:0] exact, input logic sat);
    sat_res_t r;
    r = sat_sel(exact_t'($signed(exact)), sat, WIDTH);
    return {r.ovf, r.res[WIDTH-1:0]};
  endfunction

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  sadder_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .sum_c  (exact_sum_c),
    .diff_c (exact_diff_c)
  );

  always_comb begin
    sum_sel_c  = pick(exact_sum_c, s1_sat);
    diff_sel_c = pick(exact_diff_c, s1_sat);
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_sat <= sat_en;
      end
    end
  end

  // Stage 2: registered results; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      diff      <= '0;
      ovf_sum   <= 1'b0;
      ovf_diff  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum      <= sum_sel_c[WIDTH-1:0];
        ovf_sum  <= sum_sel_c[WIDTH];
        diff     <= diff_sel_c[WIDTH-1:0];
        ovf_diff <= diff_sel_c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_sadder_pipe.sv
// Directed and backpressure bench for sadder_pipe at WIDTH = 32.
`timescale 1ns/1ps
module tb_sadder_pipe;

  localparam int unsigned W = 32;
  localparam int MAX_CYC = 3000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sat_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic         ovf_sum;
  logic         ovf_diff;

  int vectors = 0;
  int miscompares = 0;

  logic [65:0] exp_q[$];
  logic [65:0] held;
  logic [65:0] cur;
  logic        stalled;
  int          pushed;
  int          popped;
  int          cyc;

  sadder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .diff      (diff),
    .ovf_sum   (ovf_sum),
    .ovf_diff  (ovf_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact 64-bit arithmetic, then range test against the signed 32-bit limits.
  function automatic logic [32:0] ref_sat(input longint x, input logic s);
    logic [32:0] r;
    if (x > 64'sd2147483647)
      r = {1'b1, s ? 32'h7FFF_FFFF : 32'(x)};
    else if (x < -64'sd2147483648)
      r = {1'b1, s ? 32'h8000_0000 : 32'(x)};
    else
      r = {1'b0, 32'(x)};
    return r;
  endfunction

  function automatic logic [65:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic s);
    longint sa;
    longint sb;
    logic [32:0] rs;
    logic [32:0] rd;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    rs = ref_sat(sa + sb, s);
    rd = ref_sat(sa - sb, s);
    return {rs[31:0], rd[31:0], rs[32], rd[32]};
  endfunction

  // One beat on an empty pipe: accepted at edge N, absent after N, present after N+1.
  task automatic run_beat(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic [31:0] es, input logic [31:0] ed,
                          input logic eos, input logic eod);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta;
    b = tb;
    sat_en = ts;
    #1 chk({tag, "/accept"}, 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sat_en = 1'b1;
    chk({tag, "/early"}, 128'(out_valid), 128'(1'b0));
    @(negedge clk);
    chk({tag, "/result"}, 128'({out_valid, sum, diff, ovf_sum, ovf_diff}),
        128'({1'b1, es, ed, eos, eod}));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 32'd5;
    b = 32'hFFFF_FFFD;
    sat_en = 1'b0;

    // Held in reset with in_valid high: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = $urandom;
      #1 chk("reset_hold", 128'({in_ready, out_valid, sum, diff, ovf_sum, ovf_diff}),
             128'({1'b1, 67'b0}));
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    run_beat("p5_m3",      32'd5,          32'hFFFF_FFFD, 1'b0, 32'd2,          32'd8,          1'b0, 1'b0);
    run_beat("max_p1_sat", 32'h7FFF_FFFF,  32'd1,         1'b1, 32'h7FFF_FFFF,  32'h7FFF_FFFE,  1'b1, 1'b0);
    run_beat("max_p1_wrp", 32'h7FFF_FFFF,  32'd1,         1'b0, 32'h8000_0000,  32'h7FFF_FFFE,  1'b1, 1'b0);
    run_beat("z_min_sat",  32'd0,          32'h8000_0000, 1'b1, 32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 1'b1);
    run_beat("z_min_wrp",  32'd0,          32'h8000_0000, 1'b0, 32'h8000_0000,  32'h8000_0000,  1'b0, 1'b1);
    run_beat("min_p1_sat", 32'h8000_0000,  32'd1,         1'b1, 32'h8000_0001,  32'h8000_0000,  1'b0, 1'b1);
    run_beat("min_min_sat",32'h8000_0000,  32'h8000_0000, 1'b1, 32'h8000_0000,  32'd0,          1'b1, 1'b0);
    run_beat("min_min_wrp",32'h8000_0000,  32'h8000_0000, 1'b0, 32'd0,          32'd0,          1'b1, 1'b0);
    run_beat("m1_m1",      32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE,  32'd0,          1'b0, 1'b0);

    // Random stream with random backpressure against the reference queue.
    pushed = 0;
    popped = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while ((pushed < 100 || exp_q.size() != 0) && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      cur = {sum, diff, ovf_sum, ovf_diff};
      if (stalled) chk("stall_hold", 128'({out_valid, cur}), 128'({1'b1, held}));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_beat", 128'(out_valid), 128'(1'b0));
        else chk("stream", 128'(cur), 128'(exp_q[0]));
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (pushed < 100) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       a = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
        1:       a = 32'h8000_0000 + 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 31)) - 32'd16 : $urandom;
      sat_en = 1'($urandom_range(0, 1));
      #1 chk("in_ready", 128'(in_ready), 128'(!(exp_q.size() == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sat_en));
        pushed++;
      end
      stalled = out_valid && !out_ready;
      held = cur;
    end
    chk("stream_bound", 128'(cyc < MAX_CYC), 128'(1'b1));
    chk("beats_out", 128'(popped), 128'(100));

    // Fill both stages under backpressure, then reset mid-flight.
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'd11;
    b = 32'd22;
    sat_en = 1'b0;
    @(negedge clk);
    a = 32'd33;
    b = 32'd44;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("full_stall", 128'({out_valid, in_ready, sum}), 128'({1'b1, 1'b0, 32'd33}));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 128'({in_ready, out_valid, sum, diff, ovf_sum, ovf_diff}),
           128'({1'b1, 67'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ghost", 128'(out_valid), 128'(1'b0));
    end

    run_beat("post_reset", 32'd100, 32'hFFFF_FFCE, 1'b1, 32'd50, 32'd150, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
